// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver.
// Segment patterns are active-low {G,F,E,D,C,B,A}.
package seg7_pkg;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  localparam logic [6:0] SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Bit i set when some nibble at or above digit i is non-zero.
  function automatic logic [7:0] lz_keep(logic [31:0] d);
    logic [7:0] k;
    k[0] = 1'b1;
    for (int i = 1; i < 8; i++) begin
      k[i] = |(d >> (4 * i));
    end
    return k;
  endfunction

endpackage

// File: rtl/seg7_scan_hex7_decode.sv
// Hex nibble to active-low seven-segment pattern.
// Purely combinational lookup.
module hex7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = SEG_LUT[nib];

endmodule

// File: rtl/seg7_scan.sv
// Eight-digit multiplexed seven-segment driver with per-frame capture.
// Optional leading-zero suppression: SEG7_SCAN_ZERO_BLANK_EN.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int DIV_WIDTH    = 15,
  parameter int BLANK_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data,
  input  logic [7:0]  en,
  input  logic [7:0]  dot,
  output logic [7:0]  seg_ca,
  output logic [7:0]  seg_an,
  output logic        frame_start
);

  localparam logic [DIV_WIDTH-1:0] CNT_ONE =
    {{(DIV_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DIV_WIDTH-1:0] BLANK =
    DIV_WIDTH'(BLANK_CYCLES);

  logic [DIV_WIDTH-1:0] cnt;
  logic [2:0]           idx;
  logic [31:0]          s_data;
  logic [7:0]           s_en;
  logic [7:0]           s_dot;
  logic [7:0]           on;
  logic                 cap;
  logic                 blank;
  logic [3:0]           nib;
  logic [6:0]           seg;

  assign cap   = (cnt == '0) && (idx == 3'd0);
  // cnt==0 keeps a dark clock between digits even with no blank window
  assign blank = (cnt < BLANK) || (cnt == '0);
  assign nib   = s_data[{idx, 2'b00} +: 4];

  hex7_decode u_dec (
    .nib (nib),
    .seg (seg)
  );

`ifdef SEG7_SCAN_ZERO_BLANK_EN
  logic [7:0] s_keep;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_keep <= '0;
    end else if (cap) begin
      s_keep <= lz_keep(data);
    end
  end

  assign on = s_en & s_keep;
`else
  assign on = s_en;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      idx    <= 3'd0;
      s_data <= '0;
      s_en   <= '0;
      s_dot  <= '0;
    end else begin
      cnt <= cnt + CNT_ONE;
      if (&cnt) begin
        idx <= idx + 3'd1;
      end
      if (cap) begin
        s_data <= data;
        s_en   <= en;
        s_dot  <= dot;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_an      <= AN_OFF;
      seg_ca      <= SEG_OFF;
      frame_start <= 1'b0;
    end else begin
      frame_start <= cap;
      seg_ca      <= {~s_dot[idx], seg};
      if (blank || !on[idx]) begin
        seg_an <= AN_OFF;
      end else begin
        seg_an <= ~(8'h01 << idx);
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// Directed plus randomized check of seg7_scan against a
// frame-level reference model (DIV_WIDTH=4, BLANK_CYCLES=2).
module tb_seg7_scan;

  localparam int DW    = 4;
  localparam int BC    = 2;
  localparam int SLOT  = 1 << DW;
  localparam int FRAME = 8 * SLOT;

  logic        clk;
  logic        rst;
  logic [31:0] data;
  logic [7:0]  en;
  logic [7:0]  dot;
  logic [7:0]  seg_ca;
  logic [7:0]  seg_an;
  logic        frame_start;

  seg7_scan #(
    .DIV_WIDTH    (DW),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .data        (data),
    .en          (en),
    .dot         (dot),
    .seg_ca      (seg_ca),
    .seg_an      (seg_an),
    .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] seg_tab [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  int n_cmp;
  int n_bad;
  int st;
  int fs_cnt;
  int hi_lit;
  logic [7:0]  lit_acc;
  logic [31:0] m_data;
  logic [7:0]  m_en;
  logic [7:0]  m_dot;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic digit_on(int i);
    logic ok;
    ok = m_en[i];
`ifdef SEG7_SCAN_ZERO_BLANK_EN
    if (i > 0 && (m_data >> (4 * i)) == 0) ok = 1'b0;
`endif
    return ok;
  endfunction

  // One clock: predict from the position in the frame, then compare.
  task automatic tick();
    int d;
    int ph;
    logic [7:0] e_an;
    logic [7:0] e_ca;
    logic       e_fs;
    d    = st / SLOT;
    ph   = st % SLOT;
    e_an = ((ph >= BC) && digit_on(d)) ? ~(8'h01 << d) : 8'hFF;
    e_ca = {~m_dot[d], seg_tab[m_data[4*d +: 4]]};
    e_fs = (st == 0);
    if (st == 0) begin
      m_data = data;
      m_en   = en;
      m_dot  = dot;
    end
    st = (st + 1) % FRAME;
    @(posedge clk);
    @(negedge clk);
    chk("seg_an", seg_an, e_an);
    chk("frame_start", frame_start, e_fs);
    if (ph >= BC) chk("seg_ca", seg_ca, e_ca);
    chk("one_anode", $countones(~seg_an) <= 1, 1);
    if (frame_start) fs_cnt++;
    if (seg_an[7:4] != 4'hF) hi_lit++;
    lit_acc |= ~seg_an;
  endtask

  task automatic goto(int c);
    while (st != c) tick();
  endtask

  task automatic run(int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst    = 1'b0;
    st     = 0;
    m_data = '0;
    m_en   = '0;
    m_dot  = '0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    st    = 0;
    rst   = 1'b0;
    data  = '0;
    en    = '0;
    dot   = '0;
    #3 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_an", seg_an, 8'hFF);
    chk("rst_ca", seg_ca, 8'hFF);
    chk("rst_fs", frame_start, 0);

    // digits show 89ABCDEF, all enabled
    data = 32'h89AB_CDEF;
    en   = 8'hFF;
    dot  = 8'h00;
    release_rst();
    goto(8);
    tick();
    chk("d0_an", seg_an, 8'hFE);
    chk("d0_ca", seg_ca, 8'h8E);
    goto(7 * SLOT + 8);
    tick();
    chk("d7_an", seg_an, 8'h7F);
    chk("d7_ca", seg_ca, 8'h80);
    goto(0);
    fs_cnt = 0;
    run(3 * FRAME);
    chk("fs_per_3_frames", fs_cnt, 3);

    // mid-frame data change must wait for the next capture
    goto(3 * SLOT);
    data = 32'h1234_5678;
    goto(4 * SLOT + 8);
    tick();
    chk("old_d4", seg_ca[6:0], 7'h03);
    goto(8);
    tick();
    chk("new_d0", seg_ca, 8'h80);

    // upper digits disabled, DP on digit 0 only
    en  = 8'h0F;
    dot = 8'h01;
    goto(0);
    tick();
    hi_lit = 0;
    run(FRAME - 1);
    chk("hi_dark", hi_lit, 0);
    goto(8);
    tick();
    chk("dp0", seg_ca[7], 0);
    goto(2 * SLOT + 8);
    tick();
    chk("dp2", seg_ca[7], 1);

    // random inputs changing at random times
    for (int k = 0; k < 12 * FRAME; k++) begin
      if ($urandom_range(39) == 0) begin
        data = $urandom;
        en   = 8'($urandom);
        dot  = 8'($urandom);
      end
      tick();
    end

    // reset in the middle of digit 5
    goto(5 * SLOT + 5);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_an", seg_an, 8'hFF);
    chk("mid_rst_ca", seg_ca, 8'hFF);
    chk("mid_rst_fs", frame_start, 0);
    @(negedge clk);
    data = $urandom;
    en   = 8'hFF;
    dot  = 8'h00;
    release_rst();
    lit_acc = '0;
    run(SLOT);
    chk("first_lit_d0", lit_acc, 8'h01);
    run(2 * FRAME);

    // leading-zero suppression case
    data = 32'h0000_00A0;
    en   = 8'hFF;
    dot  = 8'h00;
    goto(0);
    tick();
    goto(SLOT + 8);
    tick();
    chk("lz_d1_ca", seg_ca[6:0], 7'h08);
    goto(8);
    tick();
    chk("lz_d0_ca", seg_ca[6:0], 7'h40);
    goto(0);
    lit_acc = '0;
    run(FRAME);
`ifdef SEG7_SCAN_ZERO_BLANK_EN
    chk("lz_lit_set", lit_acc, 8'h03);
`else
    chk("lz_lit_set", lit_acc, 8'hFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
